pal_cfg_loader: RTL and testbench

Framed serial configuration loader that sits directly upstream of the PAL fabric's configuration shift chain. It hunts for a sync word in a raw serial bitstream, checks the declared length against the fabric size, and streams payload bits into the PAL one bit per shift pulse while computing CRC-8. The fabric is told to apply its configuration only after the trailing CRC matches. Any error leaves the previously applied configuration active.

---
 rtl/pal_cfg_loader.sv | 212 +++++++++++++++++++++
 tb/tb_pal_cfg_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - framed serial configuration loader for the PAL shift chain
//
// Hunts for SYNC in a serial bitstream, checks the 16-bit declared length
// against CFG_BITS, streams the payload into the PAL chain one bit per
// cfg_shift pulse while accumulating CRC-8 (poly 0x07, init 0x00), and
// issues cfg_apply only when the trailing CRC matches.
//
// Ports:
//   clk       in   clock, rising edge
//   res       in   asynchronous active-high reset
//   in_bit    in   serial frame bit (already synchronous to clk)
//   in_valid  in   one-cycle strobe qualifying in_bit
//   abort     in   synchronous return to HUNT, flags untouched
//   cfg_bit   out  bit presented to the PAL config chain
//   cfg_shift out  one-cycle shift pulse for the PAL chain
//   cfg_apply out  one-cycle pulse, PAL latches the shifted configuration
//   busy      out  high while in LEN, PAYLOAD or CRC
//   done      out  sticky, set by a good frame
//   err       out  sticky: 00 none, 01 bad length, 10 CRC mismatch, 11 timeout
module pal_cfg_loader #(
  parameter int         CFG_BITS = 256,
  parameter int         TIMEOUT  = 1023,
  parameter logic [7:0] SYNC     = 8'hA5
) (
  input  logic       clk,
  input  logic       res,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       abort,
  output logic       cfg_bit,
  output logic       cfg_shift,
  output logic       cfg_apply,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int CW = $clog2(CFG_BITS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   CFG_LEN  = 16'(CFG_BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(CFG_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CRC, S_APPLY} state_t;

  state_t state, next_state;

  // Shift registers keep only the bits that are still needed: together with
  // the incoming bit they form the full 8/16/8-bit field for comparison.
  logic [6:0]    window,  window_nxt;
  logic [14:0]   len_sr,  len_nxt;
  logic [6:0]    rx_sr,   rx_nxt;
  logic [3:0]    fcnt,    fcnt_nxt;
  logic [CW-1:0] cnt,     cnt_nxt;
  logic [7:0]    crc,     crc_nxt;
  logic [IW-1:0] idle,    idle_nxt;

  logic       cfg_bit_nxt, cfg_shift_nxt, cfg_apply_nxt, busy_nxt, done_nxt;
  logic [1:0] err_nxt;

  logic [7:0]  win_shift;
  logic [15:0] len_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  crc_step;
  logic        in_frame, timeout_hit;
  logic        sync_hit, len_last, pay_last, crc_last;

  assign win_shift = {window, in_bit};
  assign len_shift = {len_sr, in_bit};
  assign rx_shift  = {rx_sr, in_bit};
  assign crc_step  = {crc[6:0], 1'b0} ^ ((crc[7] ^ in_bit) ? 8'h07 : 8'h00);

  assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CRC);
  assign timeout_hit = in_frame && (idle == IDLE_MAX);
  assign sync_hit    = in_valid && (win_shift == SYNC);
  assign len_last    = in_valid && (fcnt == 4'd15);
  assign pay_last    = in_valid && (cnt == LAST_IDX);
  assign crc_last    = in_valid && (fcnt == 4'd7);

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_HUNT;
    else     state <= next_state;
  end

  // Next-state logic; abort outranks the timeout, which outranks bit handling
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_HUNT;
    end else if (timeout_hit) begin
      next_state = S_HUNT;
    end else begin
      case (state)
        S_HUNT:    if (sync_hit) next_state = S_LEN;
        S_LEN:     if (len_last) next_state = (len_shift == CFG_LEN) ? S_PAYLOAD : S_HUNT;
        S_PAYLOAD: if (pay_last) next_state = S_CRC;
        S_CRC:     if (crc_last) next_state = (rx_shift == crc) ? S_APPLY : S_HUNT;
        S_APPLY:   next_state = S_HUNT;
        default:   next_state = S_HUNT;
      endcase
    end
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    window_nxt    = window;
    len_nxt       = len_sr;
    rx_nxt        = rx_sr;
    fcnt_nxt      = fcnt;
    cnt_nxt       = cnt;
    crc_nxt       = crc;
    idle_nxt      = idle;
    cfg_bit_nxt   = cfg_bit;
    cfg_shift_nxt = 1'b0;
    done_nxt      = done;
    err_nxt       = err;
    cfg_apply_nxt = (next_state == S_APPLY);
    busy_nxt      = (next_state == S_LEN) || (next_state == S_PAYLOAD) || (next_state == S_CRC);

    if (abort) begin
      window_nxt = '0;
      idle_nxt   = '0;
    end else if (timeout_hit) begin
      err_nxt  = 2'b11;
      idle_nxt = '0;
    end else begin
      if (!busy_nxt || in_valid)  idle_nxt = '0;
      else if (idle != IDLE_MAX)  idle_nxt = idle + IW'(1);

      case (state)
        S_HUNT: begin
          if (in_valid) begin
            if (sync_hit) begin
              // Cleared window cannot re-match SYNC until a full new word arrives
              window_nxt = '0;
              fcnt_nxt   = '0;
              cnt_nxt    = '0;
              crc_nxt    = '0;
              done_nxt   = 1'b0;
              err_nxt    = 2'b00;
            end else begin
              window_nxt = win_shift[6:0];
            end
          end
        end
        S_LEN: begin
          if (in_valid) begin
            len_nxt  = len_shift[14:0];
            fcnt_nxt = fcnt + 4'd1;
            if (len_last && (len_shift != CFG_LEN)) err_nxt = 2'b01;
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            cfg_bit_nxt   = in_bit;
            cfg_shift_nxt = 1'b1;
            crc_nxt       = crc_step;
            cnt_nxt       = pay_last ? '0 : cnt + CW'(1);
          end
        end
        S_CRC: begin
          if (in_valid) begin
            rx_nxt = rx_shift[6:0];
            if (crc_last) begin
              fcnt_nxt = '0;
              if (rx_shift == crc) done_nxt = 1'b1;
              else                 err_nxt  = 2'b10;
            end else begin
              fcnt_nxt = fcnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      window    <= '0;
      len_sr    <= '0;
      rx_sr     <= '0;
      fcnt      <= '0;
      cnt       <= '0;
      crc       <= '0;
      idle      <= '0;
      cfg_bit   <= 1'b0;
      cfg_shift <= 1'b0;
      cfg_apply <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 2'b00;
    end else begin
      window    <= window_nxt;
      len_sr    <= len_nxt;
      rx_sr     <= rx_nxt;
      fcnt      <= fcnt_nxt;
      cnt       <= cnt_nxt;
      crc       <= crc_nxt;
      idle      <= idle_nxt;
      cfg_bit   <= cfg_bit_nxt;
      cfg_shift <= cfg_shift_nxt;
      cfg_apply <= cfg_apply_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - directed table-driven bench for pal_cfg_loader
module tb_pal_cfg_loader;

  localparam int         CFG_BITS = 16;
  localparam int         TIMEOUT  = 8;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic       clk = 1'b0;
  logic       res, in_bit, in_valid, abort;
  logic       cfg_bit, cfg_shift, cfg_apply, busy, done;
  logic [1:0] err;

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_BITS(CFG_BITS), .TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
    .clk(clk), .res(res), .in_bit(in_bit), .in_valid(in_valid), .abort(abort),
    .cfg_bit(cfg_bit), .cfg_shift(cfg_shift), .cfg_apply(cfg_apply),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    string       name;
    bit          garbage;
    logic [15:0] len;
    logic [15:0] payload;
    logic [7:0]  crc;
    int          gap_max;
    bit          body;
    int          exp_shifts;
    int          exp_apply;
    logic        exp_done;
    logic [1:0]  exp_err;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic bits_q[$];
  int   apply_total = 0;

  // Output monitor: each pulse is one cycle wide, so negedge sampling sees it once
  always @(negedge clk) begin
    if (cfg_shift) bits_q.push_back(cfg_bit);
    if (cfg_apply) apply_total++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [15:0] p);
    logic [7:0] c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ p[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = v;
    in_bit   = b;
  endtask

  task automatic send_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, val[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic send_frame(input vec_t v);
    if (v.garbage) begin
      drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    end
    send_bits({8'h00, SYNC}, 8);
    send_bits(v.len, 16);
    if (v.body) begin
      for (int i = 15; i >= 0; i--) begin
        drive(1'b1, v.payload[i]);
        idle(int'($urandom_range(v.gap_max, 0)));
      end
      send_bits({8'h00, v.crc}, 8);
    end
    idle(4);
  endtask

  vec_t vt[8];
  int   base_s, base_a;
  logic [15:0] w;

  initial begin
    vt[0] = '{"zero_b2b",      0, 16'h0010, 16'h0000, 8'h00, 0, 1, 16, 1, 1'b1, 2'b00};
    vt[1] = '{"one_crc07",     0, 16'h0010, 16'h0001, 8'h07, 0, 1, 16, 1, 1'b1, 2'b00};
    vt[2] = '{"bad_crc",       0, 16'h0010, 16'h0000, 8'h01, 0, 1, 16, 0, 1'b0, 2'b10};
    vt[3] = '{"bad_len",       0, 16'h0011, 16'h0000, 8'h00, 0, 0,  0, 0, 1'b0, 2'b01};
    vt[4] = '{"recover_gaps",  0, 16'h0010, 16'h0100, 8'h15, 7, 1, 16, 1, 1'b1, 2'b00};
    vt[5] = '{"len_zero",      0, 16'h0000, 16'h0000, 8'h00, 0, 0,  0, 0, 1'b0, 2'b01};
    vt[6] = '{"garbage_pref",  1, 16'h0010, 16'hABCD, 8'h00, 3, 1, 16, 1, 1'b1, 2'b00};
    vt[7] = '{"random_gaps",   0, 16'h0010, 16'h0000, 8'h00, 7, 1, 16, 1, 1'b1, 2'b00};
    vt[6].crc     = crc_model(vt[6].payload);
    vt[7].payload = 16'($urandom);
    vt[7].crc     = crc_model(vt[7].payload);

    res = 1'b1; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_cfg_bit",   32'(cfg_bit),   32'd0);
    chk("rst_cfg_shift", 32'(cfg_shift), 32'd0);
    chk("rst_cfg_apply", 32'(cfg_apply), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);

    for (int i = 0; i < 8; i++) begin
      base_s = bits_q.size();
      base_a = apply_total;
      send_frame(vt[i]);
      chk({vt[i].name, "_shifts"}, 32'(bits_q.size() - base_s), 32'(vt[i].exp_shifts));
      chk({vt[i].name, "_apply"},  32'(apply_total - base_a),   32'(vt[i].exp_apply));
      chk({vt[i].name, "_done"},   32'(done),                   32'(vt[i].exp_done));
      chk({vt[i].name, "_err"},    32'(err),                    32'(vt[i].exp_err));
      chk({vt[i].name, "_busy"},   32'(busy),                   32'd0);
      if (vt[i].exp_shifts == 16) begin
        w = '0;
        for (int k = 0; k < 16; k++)
          if (base_s + k < bits_q.size()) w[15-k] = bits_q[base_s + k];
        chk({vt[i].name, "_bits"}, 32'(w), 32'(vt[i].payload));
      end
    end

    // Timeout after payload bit 5: 8 idle edges are tolerated, the 9th errors out
    base_s = bits_q.size();
    base_a = apply_total;
    send_bits({8'h00, SYNC}, 8);
    chk("tmo_busy_pre_sync", 32'(busy), 32'd0);
    send_bits(16'h0010, 16);
    chk("tmo_busy_after_sync", 32'(busy), 32'd1);
    send_bits(16'h0016, 5);
    idle(9);
    chk("tmo_err_at_8",  32'(err),  32'd0);
    chk("tmo_busy_at_8", 32'(busy), 32'd1);
    idle(1);
    chk("tmo_err",    32'(err),  32'd3);
    chk("tmo_busy",   32'(busy), 32'd0);
    chk("tmo_shifts", 32'(bits_q.size() - base_s), 32'd5);
    idle(3);
    chk("tmo_apply",  32'(apply_total - base_a), 32'd0);

    // Abort mid-payload, asserted together with in_valid
    base_s = bits_q.size();
    base_a = apply_total;
    send_bits({8'h00, SYNC}, 8);
    send_bits(16'h0010, 16);
    send_bits(16'h0000, 6);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    drive(1'b0, 1'b0);
    chk("abort_busy",   32'(busy), 32'd0);
    send_bits(16'h0000, 10);
    send_bits(16'h0000, 8);
    idle(4);
    chk("abort_shifts", 32'(bits_q.size() - base_s), 32'd6);
    chk("abort_apply",  32'(apply_total - base_a),   32'd0);
    chk("abort_done",   32'(done), 32'd0);
    chk("abort_err",    32'(err),  32'd0);

    // Reset mid-payload
    base_a = apply_total;
    send_frame(vt[0]);
    base_a = apply_total;
    send_bits({8'h00, SYNC}, 8);
    send_bits(16'h0010, 16);
    send_bits(16'h000F, 4);
    @(negedge clk);
    in_valid = 1'b0;
    res = 1'b1;
    #1;
    chk("res_cfg_bit", 32'(cfg_bit), 32'd0);
    chk("res_busy",    32'(busy),    32'd0);
    chk("res_done",    32'(done),    32'd0);
    @(negedge clk);
    res = 1'b0;
    send_bits(16'h0000, 12);
    send_bits(16'h0000, 8);
    idle(4);
    chk("res_apply", 32'(apply_total - base_a), 32'd0);
    chk("res_err",   32'(err),  32'd0);
    chk("res_busy2", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
